// File: rtl/tpu_mm_ctrl_if.sv
// Handshake and TPU bus bundle for the matmul job controller.
// The controller connects through the slave modport; whoever drives jobs
// and emulates the TPU bus connects through the master modport.
interface tpu_mm_ctrl_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);
  // job control
  logic             start;
  logic             clr_c;
  logic             busy;
  logic             done;
  // operand stream (A rows then B rows)
  logic             in_valid;
  logic [DATAW-1:0] in_data;
  logic             in_ready;
  // result stream (C words)
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_ready;
  // TPU register bus
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    output start, clr_c, in_valid, in_data, out_ready, tpu_rdata,
    input  busy, done, in_ready, out_valid, out_data, tpu_addr, tpu_r_w, tpu_wdata
  );

  modport slave (
    input  start, clr_c, in_valid, in_data, out_ready, tpu_rdata,
    output busy, done, in_ready, out_valid, out_data, tpu_addr, tpu_r_w, tpu_wdata
  );
endinterface

// File: rtl/tpu_mm_ctrl.sv
// Matmul job sequencer for a DIMxDIM systolic TPU.
// Streams A and B rows onto the TPU bus, optionally zeroes C, kicks the
// multiply, waits a fixed latency, then reads C back into an output stream
// with valid/ready flow control.
module tpu_mm_ctrl #(
  parameter int DIM       = 8,
  parameter int DATAW     = 64,
  parameter int ADDRW     = 16,
  parameter int MM_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  tpu_mm_ctrl_if.slave  bus
);

  // Word counter spans 0..2*DIM-1 (C has two half-words per row);
  // the same counter indexes A/B rows, which only go to DIM-1.
  localparam int CW = $clog2(2 * DIM + 1);
  localparam int WW = $clog2(MM_CYCLES + 1);

  localparam logic [ADDRW-1:0] A_BASE = ADDRW'(12'h100);
  localparam logic [ADDRW-1:0] B_ADDR = ADDRW'(12'h200);
  localparam logic [ADDRW-1:0] C_BASE = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] MM_CMD = ADDRW'(12'h400);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLR_C,
    MM_ISSUE,
    MM_WAIT,
    READ_C,
    FIN
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WW-1:0]    wait_q;
  logic             clr_q;
  logic             out_valid_q;
  logic [DATAW-1:0] out_data_q;

  logic             loading;
  logic             rd_en;
  logic             last_row;
  logic             last_word;
  logic             last_wait;
  logic [ADDRW-1:0] word_off;

  assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
  // A C read may only be launched when the output register is free or
  // being drained this cycle, so a stalled word is never overwritten.
  assign rd_en     = (state_q == READ_C) && (!out_valid_q || bus.out_ready);
  assign last_row  = (cnt_q == CW'(DIM - 1));
  assign last_word = (cnt_q == CW'(2 * DIM - 1));
  assign last_wait = (wait_q == WW'(MM_CYCLES - 1));
  // Row stride 8 for A; for C, word k = {row, half} so k<<3 equals
  // (row<<4)|(half<<3).
  assign word_off  = ADDRW'(cnt_q) << 3;

  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = loading;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  // FIN holds the final word; done marks its acceptance.
  assign bus.done      = (state_q == FIN) && out_valid_q && bus.out_ready;

  // TPU bus decode: idle (all zero) unless the current state issues an access.
  always_comb begin
    bus.tpu_addr  = '0;
    bus.tpu_r_w   = 1'b0;
    bus.tpu_wdata = '0;
    case (state_q)
      LOAD_A: begin
        if (bus.in_valid) begin
          bus.tpu_addr  = A_BASE | word_off;
          bus.tpu_r_w   = 1'b1;
          bus.tpu_wdata = bus.in_data;
        end
      end
      LOAD_B: begin
        if (bus.in_valid) begin
          bus.tpu_addr  = B_ADDR;
          bus.tpu_r_w   = 1'b1;
          bus.tpu_wdata = bus.in_data;
        end
      end
      CLR_C: begin
        bus.tpu_addr = C_BASE | word_off;
        bus.tpu_r_w  = 1'b1;
      end
      MM_ISSUE: begin
        bus.tpu_addr = MM_CMD;
      end
      READ_C: begin
        if (rd_en) begin
          bus.tpu_addr = C_BASE | word_off;
        end
      end
      default: ;
    endcase
  end

  // Job FSM with its counters and the registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      clr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            clr_q   <= bus.clr_c;
            cnt_q   <= '0;
            state_q <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (bus.in_valid) begin
            if (last_row) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            if (last_row) begin
              cnt_q   <= '0;
              state_q <= clr_q ? CLR_C : MM_ISSUE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CLR_C: begin
          if (last_word) begin
            cnt_q   <= '0;
            state_q <= MM_ISSUE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MM_ISSUE: begin
          wait_q  <= '0;
          state_q <= MM_WAIT;
        end
        MM_WAIT: begin
          if (last_wait) begin
            wait_q  <= '0;
            state_q <= READ_C;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        READ_C: begin
          if (rd_en) begin
            out_data_q  <= bus.tpu_rdata;
            out_valid_q <= 1'b1;
            if (last_word) begin
              cnt_q   <= '0;
              state_q <= FIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FIN: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mm_ctrl.sv
// Self-checking bench for tpu_mm_ctrl: directed jobs with randomized data
// and handshake patterns, checked against a transaction-level model of the
// expected TPU bus access list and C output stream.
module tb_tpu_mm_ctrl;
  localparam int DIM       = 8;
  localparam int DATAW     = 64;
  localparam int ADDRW     = 16;
  localparam int MM_CYCLES = 32;
  localparam int NW        = 2 * DIM;
  localparam int IW        = $clog2(NW);
  localparam int BUDGET    = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_mm_ctrl_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  tpu_mm_ctrl #(
    .DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .MM_CYCLES(MM_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int job_no = 0;

  logic [DATAW-1:0] ops  [NW];
  logic [DATAW-1:0] cmem [NW];

  // TPU model: C region reads return this job's C contents; anything else
  // returns a marker so a wrong read address shows up in the output data.
  logic [DATAW-1:0] rdata_m;
  logic [IW-1:0]    ridx;
  always_comb begin
    ridx    = IW'((bus.tpu_addr - 16'h300) >> 3);
    rdata_m = 64'hBAD0_BAD0_BAD0_BAD0;
    if (!bus.tpu_r_w && bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380 && bus.tpu_addr[2:0] == 3'd0)
      rdata_m = cmem[ridx];
  end
  assign bus.tpu_rdata = rdata_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus / stream monitor, sampled on the falling edge.
  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [63:0] data;
    int          cyc;
  } op_t;

  op_t         opq[$];
  logic [63:0] outq[$];
  int          done_cnt = 0;
  int          cyc = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.tpu_addr != 0 || bus.tpu_r_w)
        opq.push_back('{bus.tpu_addr, bus.tpu_r_w, bus.tpu_wdata, cyc});
      else
        chk("idle_wdata", bus.tpu_wdata, 64'd0);
      if (bus.in_ready && !bus.in_valid)
        chk("gap_idle_bus", 64'({bus.tpu_r_w, bus.tpu_addr}), 64'd0);
      if (prev_stall)
        chk("stall_hold", bus.out_data, prev_data);
      if (bus.out_valid && !bus.out_ready)
        chk("stall_noread", 64'(bus.tpu_addr), 64'd0);
      if (bus.out_valid && bus.out_ready)
        outq.push_back(bus.out_data);
      if (bus.done)
        done_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 0;
    end
  end

  // One job. Entered and left just after a rising edge.
  // in_mode : 0 always valid, 1 valid every other cycle, 2 random
  // out_mode: 0 always ready, 1 hold ready low 5 cycles on first word, 2 random
  task automatic run_job(input bit clr, input int in_mode, input int out_mode,
                         input bit ident, input bit busy_start, input bit abort,
                         input bit b2b);
    int idx = 0;
    int cnt = 0;
    int stalled = 0;
    int c400 = -1;
    int i400;
    int nops;
    int nout;
    bit hs;
    bit seen_done = 0;
    logic [15:0] e_addr[$];
    logic        e_rw[$];
    logic [63:0] e_data[$];

    job_no++;
    for (int i = 0; i < DIM; i++) begin
      ops[i]       = ident ? (64'd1 << (8 * i)) : {$urandom, $urandom};
      ops[DIM + i] = ident ? {8{8'(i + 1)}} : {$urandom, $urandom};
    end
    for (int k = 0; k < NW; k++) cmem[k] = {$urandom, $urandom};
    opq.delete();
    outq.delete();
    done_cnt = 0;

    bus.start = 1'b1;
    bus.clr_c = clr;
    @(posedge clk); #1;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    bus.clr_c = 1'b0;

    while (!seen_done && cnt < BUDGET) begin
      bus.in_valid = (idx < NW) && (in_mode == 0 || (in_mode == 1 && cnt % 2 == 0) ||
                                    (in_mode == 2 && $urandom_range(1) == 1));
      bus.in_data  = (idx < NW) ? ops[idx] : '0;
      if (out_mode == 0) bus.out_ready = 1'b1;
      else if (out_mode == 1) begin
        if (bus.out_valid && stalled < 5) begin
          bus.out_ready = 1'b0;
          stalled++;
        end else bus.out_ready = 1'b1;
      end else bus.out_ready = ($urandom_range(1) == 1);
      if (busy_start) begin
        bus.start = (cnt >= 5 && cnt < 12);
        bus.clr_c = bus.start;
      end
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (bus.done) seen_done = 1;
      if (abort && c400 < 0)
        for (int i = 0; i < opq.size(); i++) if (opq[i].addr == 16'h400) c400 = cnt;
      @(posedge clk); #1;
      if (hs) idx++;
      cnt++;
      if (abort && c400 >= 0 && cnt >= c400 + 4) begin
        // Mid-cycle asynchronous reset while waiting on the multiply.
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_out_data", bus.out_data, 64'd0);
        chk("abort_bus", 64'({bus.tpu_r_w, bus.tpu_addr}), 64'd0);
        chk("abort_wdata", bus.tpu_wdata, 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_abort_busy", 64'(bus.busy), 64'd0);
        chk("post_abort_out_valid", 64'(bus.out_valid), 64'd0);
        $display("job %0d: aborted by reset during multiply wait", job_no);
        return;
      end
    end

    bus.start    = 1'b0;
    bus.clr_c    = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_seen", 64'(seen_done), 64'd1);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("operands_taken", 64'(idx), 64'(NW));
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("out_valid_after_done", 64'(bus.out_valid), 64'd0);

    // Expected bus access list for one job.
    for (int i = 0; i < DIM; i++) begin
      e_addr.push_back(16'(256 + 8 * i)); e_rw.push_back(1'b1); e_data.push_back(ops[i]);
    end
    for (int i = 0; i < DIM; i++) begin
      e_addr.push_back(16'd512); e_rw.push_back(1'b1); e_data.push_back(ops[DIM + i]);
    end
    if (clr)
      for (int k = 0; k < NW; k++) begin
        e_addr.push_back(16'(768 + 8 * k)); e_rw.push_back(1'b1); e_data.push_back(64'd0);
      end
    e_addr.push_back(16'd1024); e_rw.push_back(1'b0); e_data.push_back(64'd0);
    for (int k = 0; k < NW; k++) begin
      e_addr.push_back(16'(768 + 8 * k)); e_rw.push_back(1'b0); e_data.push_back(64'd0);
    end

    chk("op_count", 64'(opq.size()), 64'(e_addr.size()));
    nops = (opq.size() < e_addr.size()) ? opq.size() : e_addr.size();
    for (int i = 0; i < nops; i++) begin
      chk($sformatf("op%0d_addr", i), 64'(opq[i].addr), 64'(e_addr[i]));
      chk($sformatf("op%0d_rw", i), 64'(opq[i].rw), 64'(e_rw[i]));
      chk($sformatf("op%0d_wdata", i), opq[i].data, e_data[i]);
    end
    i400 = DIM * 2 + (clr ? NW : 0);
    if (opq.size() > i400 + 1)
      chk("mm_wait_gap", 64'(opq[i400 + 1].cyc - opq[i400].cyc), 64'(MM_CYCLES + 1));

    chk("out_count", 64'(outq.size()), 64'(NW));
    nout = (outq.size() < NW) ? outq.size() : NW;
    for (int k = 0; k < nout; k++)
      chk($sformatf("out%0d", k), outq[k], cmem[k]);

    $display("job %0d: clr=%0d in_mode=%0d out_mode=%0d bus_ops=%0d out_words=%0d dones=%0d",
             job_no, clr, in_mode, out_mode, opq.size(), outq.size(), done_cnt);

    if (!b2b) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_single", 64'(done_cnt), 64'd1);
      chk("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.clr_c     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_bus", 64'({bus.tpu_r_w, bus.tpu_addr}), 64'd0);
    chk("rst_wdata", bus.tpu_wdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);   // identity A, no clear, all ready
    run_job(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // clear C first
    run_job(1'($urandom_range(1)), 1, 0, 1'b0, 1'b0, 1'b0, 1'b0); // in_valid toggling
    run_job(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);   // output stall after first word
    run_job(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);   // start while busy, then back-to-back
    run_job(1'b1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);   // started in the IDLE cycle after done
    run_job(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);   // reset during multiply wait
    run_job(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // clean job after abort
    for (int j = 0; j < 4; j++)
      run_job(1'($urandom_range(1)), 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
